gray_stream_gen: RTL and testbench



---
 rtl/gray_stream_gen.sv | 202 ++++++++++++++++++++
 tb/tb_gray_stream_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_gen.sv
// gray_stream_gen: synthetic 12-bit grayscale raster source (ramps, solid level,
// step edge) with camera-like line/frame blanking, feeding the edge path.
// Optional build macro GRAY_STREAM_GEN_CHECKER_EN turns mode 3 into a
// checkerboard of 2**CHK_LOG2 pixel squares; timing is identical either way.
module gray_stream_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned H_BLANK      = 160,
  parameter int unsigned V_BLANK      = 1000,
  parameter int unsigned H_RAMP_SHIFT = 2,
  parameter int unsigned V_RAMP_SHIFT = 3,
  parameter int unsigned CHK_LOG2     = 5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iCONT,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iLEVEL,
  output logic        oDVAL,
  output logic [11:0] oGRAY,
  output logic        oSOF,
  output logic        oEOL,
  output logic        oBUSY,
  output logic        oFRAME_DONE
);

  localparam int unsigned XW   = $clog2(H_ACTIVE);
  localparam int unsigned YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BW   = $clog2(BMAX + 1);
  localparam int unsigned HRW  = 12 + XW + H_RAMP_SHIFT;
  localparam int unsigned VRW  = 12 + YW + V_RAMP_SHIFT;

  // Reject configurations the counters and shifters cannot represent
  if (H_ACTIVE < 2 || (H_ACTIVE % 2) != 0) begin : g_bad_h_active
    $error("gray_stream_gen: H_ACTIVE must be even and >= 2");
  end
  if (V_ACTIVE < 1 || H_BLANK < 1 || V_BLANK < 1) begin : g_bad_timing
    $error("gray_stream_gen: V_ACTIVE, H_BLANK and V_BLANK must be >= 1");
  end
  if (CHK_LOG2 >= 32) begin : g_bad_chk
    $error("gray_stream_gen: CHK_LOG2 must be < 32");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [11:0]     level_q, level_d;

  logic            dval_q, dval_d;
  logic [11:0]     gray_q, gray_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [HRW-1:0]  h_ramp;
  logic [VRW-1:0]  v_ramp;

  // State, raster counters and latched frame configuration
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      mode_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      mode_q  <= mode_d;
      level_q <= level_d;
    end
  end

  // Next-state: walk pixels, line blanking, frame blanking, then restart or idle
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bcnt_d  = bcnt_q;
    mode_d  = mode_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          bcnt_d  = '0;
          mode_d  = iMODE;
          level_d = iLEVEL;
        end
      end
      S_ACTIVE: begin
        if (x_q == XW'(H_ACTIVE - 1)) begin
          state_d = S_HBLANK;
          x_d     = '0;
          bcnt_d  = '0;
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_HBLANK: begin
        if (bcnt_q == BW'(H_BLANK - 1)) begin
          bcnt_d = '0;
          if (y_q == YW'(V_ACTIVE - 1)) begin
            state_d = S_VBLANK;
          end else begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = y_q + YW'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_VBLANK: begin
        if (bcnt_q == BW'(V_BLANK - 1)) begin
          bcnt_d = '0;
          x_d    = '0;
          y_d    = '0;
          if (iCONT) begin
            state_d = S_ACTIVE;
            mode_d  = iMODE;
            level_d = iLEVEL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output lands in a register
  always_comb begin
    dval_d = (state_d == S_ACTIVE);
    sof_d  = dval_d && (x_d == '0) && (y_d == '0);
    eol_d  = dval_d && (x_d == XW'(H_ACTIVE - 1));
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_VBLANK) && (bcnt_q == BW'(V_BLANK - 1));
    gray_d = '0;
    h_ramp = HRW'(x_d) << H_RAMP_SHIFT;
    v_ramp = VRW'(y_d) << V_RAMP_SHIFT;
    if (dval_d) begin
      case (mode_d)
        2'd0: gray_d = (h_ramp > HRW'(12'hFFF)) ? 12'hFFF : h_ramp[11:0];
        2'd1: gray_d = (v_ramp > VRW'(12'hFFF)) ? 12'hFFF : v_ramp[11:0];
        2'd2: gray_d = level_d;
`ifdef GRAY_STREAM_GEN_CHECKER_EN
        default: gray_d = ((((x_d >> CHK_LOG2) & XW'(1)) != XW'(0)) ^
                           (((y_d >> CHK_LOG2) & YW'(1)) != YW'(0))) ? 12'hFFF : 12'h000;
`else
        default: gray_d = (x_d >= XW'(H_ACTIVE / 2)) ? 12'hFFF : 12'h000;
`endif
      endcase
    end
  end

  // Registered stream outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dval_q <= 1'b0;
      gray_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dval_q <= dval_d;
      gray_q <= gray_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign oDVAL       = dval_q;
  assign oGRAY       = gray_q;
  assign oSOF        = sof_q;
  assign oEOL        = eol_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_gray_stream_gen.sv
// tb_gray_stream_gen: randomized and directed stimulus for gray_stream_gen,
// checked every cycle against a frame-time reference model.
module tb_gray_stream_gen;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 6;
  localparam int unsigned HB   = 2;
  localparam int unsigned VB   = 3;
  localparam int unsigned HS   = 2;
  localparam int unsigned VS   = 10;
  localparam int unsigned CK   = 1;
  localparam int          LINE = H + HB;
  localparam int          FLEN = V * LINE + VB;

  logic        iCLK = 1'b0;
  logic        iRST, iSTART, iCONT;
  logic [1:0]  iMODE;
  logic [11:0] iLEVEL;
  logic        oDVAL, oSOF, oEOL, oBUSY, oFRAME_DONE;
  logic [11:0] oGRAY;

  gray_stream_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB),
    .H_RAMP_SHIFT(HS), .V_RAMP_SHIFT(VS), .CHK_LOG2(CK)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iCONT(iCONT),
    .iMODE(iMODE), .iLEVEL(iLEVEL),
    .oDVAL(oDVAL), .oGRAY(oGRAY), .oSOF(oSOF), .oEOL(oEOL),
    .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel value straight from the mode definitions, in plain integers
  function automatic int pixel(input int mode, input int level, input int x, input int y);
    int v;
    case (mode)
      0: begin v = x << HS; return (v > 4095) ? 4095 : v; end
      1: begin v = y << VS; return (v > 4095) ? 4095 : v; end
      2: return level;
      default: begin
`ifdef GRAY_STREAM_GEN_CHECKER_EN
        return ((((x >> CK) ^ (y >> CK)) & 1) == 1) ? 4095 : 0;
`else
        return (x >= H / 2) ? 4095 : 0;
`endif
      end
    endcase
  endfunction

  // Reference model: a frame is FLEN cycles of elapsed time t from its first pixel
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_t    = 0;
  int m_mode = 0;
  int m_level = 0;

  always @(posedge iCLK) begin
    int pos, ln;
    bit dv;
    if (iRST) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (iSTART) begin
          m_busy  = 1'b1;
          m_t     = 0;
          m_mode  = int'(iMODE);
          m_level = int'(iLEVEL);
        end
      end else begin
        m_t++;
        if (m_t == FLEN) begin
          m_done = 1'b1;
          m_t    = 0;
          if (iCONT) begin
            m_mode  = int'(iMODE);
            m_level = int'(iLEVEL);
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end
    #1;
    pos = m_t % LINE;
    ln  = m_t / LINE;
    dv  = m_busy && (m_t < V * LINE) && (pos < H);
    check("dval", 32'(oDVAL), 32'(dv));
    check("gray", 32'(oGRAY), dv ? 32'(pixel(m_mode, m_level, pos, ln)) : 32'd0);
    check("sof", 32'(oSOF), 32'(dv && m_t == 0));
    check("eol", 32'(oEOL), 32'(dv && pos == H - 1));
    check("busy", 32'(oBUSY), 32'(m_busy));
    check("frame_done", 32'(oFRAME_DONE), 32'(m_done));
  end

  // First pixel to frame-done distance
  int cyc = 0;
  int sof_cyc = -1;
  always @(posedge iCLK) begin
    cyc++;
    #2;
    if (oFRAME_DONE && sof_cyc >= 0) check("frame_len", 32'(cyc - sof_cyc), 32'(FLEN));
    if (oSOF) sof_cyc = cyc;
  end

  task automatic start_frame(input logic [1:0] mode, input logic [11:0] level, input logic cont);
    @(negedge iCLK);
    iMODE  = mode;
    iLEVEL = level;
    iCONT  = cont;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    iMODE  = 2'($urandom);
    iLEVEL = 12'($urandom);
    check("lat1_dval", 32'(oDVAL), 32'd1);
    check("lat1_sof", 32'(oSOF), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (oBUSY !== 1'b0 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (oFRAME_DONE !== 1'b1 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= budget) check("wait_done_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_t(input int target, input int budget);
    int n = 0;
    while (!(m_busy && m_t == target) && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= budget) check("wait_t_timeout", 32'(n), 32'(budget - 1));
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iCONT = 1'b0; iMODE = 2'd0; iLEVEL = 12'd0;
    repeat (3) @(negedge iCLK);
    check("reset_busy", 32'(oBUSY), 32'd0);
    check("reset_gray", 32'(oGRAY), 32'd0);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    // horizontal ramp, single frame
    start_frame(2'd0, 12'h000, 1'b0);
    wait_idle(4 * FLEN);
    check("idle_after_h", 32'(oBUSY), 32'd0);

    // vertical ramp with saturation on the later lines
    start_frame(2'd1, 12'h000, 1'b0);
    wait_idle(4 * FLEN);

    // solid level, back-to-back frames, level change mid-frame
    start_frame(2'd2, 12'h5A5, 1'b1);
    iCONT  = 1'b1;
    iMODE  = 2'd2;
    repeat (20) @(negedge iCLK);
    iLEVEL = 12'h123;
    check("f1_level_held", 32'(oDVAL ? oGRAY : 12'h5A5), 32'h5A5);
    wait_done(4 * FLEN);
    check("f2_sof", 32'(oSOF), 32'd1);
    check("f2_level", 32'(oGRAY), 32'h123);
    iCONT = 1'b0;
    wait_idle(4 * FLEN);

    // reset mid-frame at line 2 pixel 3, then immediate restart
    start_frame(2'd0, 12'h000, 1'b0);
    wait_t(2 * LINE + 3, 4 * FLEN);
    check("pre_rst_dval", 32'(oDVAL), 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    check("rst_dval", 32'(oDVAL), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    iRST = 1'b0;
    start_frame(2'd1, 12'h000, 1'b0);
    wait_idle(4 * FLEN);

    // start requests while busy are dropped
    start_frame(2'd1, 12'h000, 1'b0);
    repeat (4) @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_t(V * LINE + 1, 4 * FLEN);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_idle(4 * FLEN);
    repeat (3) @(negedge iCLK);
    check("no_queue", 32'(oBUSY), 32'd0);

    // step edge / checkerboard
    start_frame(2'd3, 12'h000, 1'b0);
    wait_idle(4 * FLEN);

    // random traffic, including occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge iCLK);
      iSTART = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 40) == 0) iCONT = 1'($urandom);
      iMODE  = 2'($urandom);
      iLEVEL = 12'($urandom);
      iRST   = ($urandom_range(0, 300) == 0);
    end
    @(negedge iCLK);
    iRST = 1'b0; iSTART = 1'b0; iCONT = 1'b0;
    repeat (3) @(negedge iCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
